// File: rtl/dev_putc_buffer.sv
// dev_putc_buffer: queues CU putc characters and drains them into the TX pipe
// one push at a time, with an idle cycle between pushes and optional LF -> CR LF.
`timescale 1ns/1ps
module dev_putc_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter bit          CRLF_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     putc,
  input  logic [7:0]               putc_char,
  output logic                     putc_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     tx_push_back,
  output logic [7:0]               tx_data_in,
  input  logic                     tx_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 9;

  typedef enum logic {IDLE, GAP} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  state_t        state;
  logic          cr_done;

  logic          wr_c;
  logic          empty_c;
  logic          send_c;
  logic          cr_c;
  logic          pop_c;
  logic          head_crlf_c;
  logic [7:0]    head_char_c;

  // Acceptance and drain decisions, all decoded from registered state.
  assign putc_ready  = (level != LW'(DEPTH));
  assign empty_c     = (level == '0);
  assign head_crlf_c = mem[head][8];
  assign head_char_c = mem[head][7:0];
  assign wr_c        = putc && putc_ready;
  assign send_c      = (state == IDLE) && !empty_c && !tx_full;
  assign cr_c        = send_c && head_crlf_c && !cr_done;
  assign pop_c       = send_c && !cr_c;

  // Storage array: entry is {crlf_flag, char}; no reset needed, level gates validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_c) begin
      mem[tail] <= {1'(CRLF_EN && (putc_char == 8'h0A)), putc_char};
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_c) begin
        tail <= tail + AW'(1);
      end
      if (pop_c) begin
        head <= head + AW'(1);
      end
      level <= level + LW'(wr_c) - LW'(pop_c);
      if (putc && !putc_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Drain FSM: at most one push every other cycle; CR of a CRLF pair pushed before popping the LF.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cr_done      <= 1'b0;
      tx_push_back <= 1'b0;
      tx_data_in   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx_push_back <= 1'b0;
          if (cr_c) begin
            tx_push_back <= 1'b1;
            tx_data_in   <= 8'h0D;
            cr_done      <= 1'b1;
            state        <= GAP;
          end else if (pop_c) begin
            tx_push_back <= 1'b1;
            tx_data_in   <= head_char_c;
            cr_done      <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          tx_push_back <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
